mem_port_arbiter: RTL

- Shares the single physical memory port between the instruction-fetch requester (I) and the data-access requester (D) of the LC-3b multicycle CPU, for the split I/D path.
- Each requester sees the same read/write/resp handshake the control FSM already drives.
- The arbiter grants one requester at a time and registers that requester's command at grant.
- It holds the command on the physical port until pmem_resp, then routes the response back to the owner only.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the I/D memory port arbiter
package mem_port_arbiter_pkg;

    localparam int LC3B_WORD_W  = 16;
    localparam int LC3B_WMASK_W = LC3B_WORD_W / 8;

    typedef logic [LC3B_WORD_W-1:0]  lc3b_word;
    typedef logic [LC3B_WMASK_W-1:0] lc3b_mem_wmask;

    typedef enum logic {
        arb_owner_i,
        arb_owner_d
    } arb_owner;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_I,
        ARB_D
    } arb_state;

    // A requester that raises read and write together is treated as a write.
    function automatic logic [1:0] cmd_encode(input logic rd, input logic wr);
        return {wr, rd & ~wr};
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - grants the physical memory port to I or D requester
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = LC3B_WORD_W,
    parameter int DATA_W = LC3B_WORD_W,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [MASK_W-1:0] i_mem_byte_enable,
    input  logic [ADDR_W-1:0] i_mem_address,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic              i_mem_resp,
    output logic [DATA_W-1:0] i_mem_rdata,

    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [MASK_W-1:0] d_mem_byte_enable,
    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic              d_mem_resp,
    output logic [DATA_W-1:0] d_mem_rdata,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [MASK_W-1:0] pmem_byte_enable,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [DATA_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [DATA_W-1:0] pmem_rdata,

    output logic              arb_busy
);

    arb_state            state;
    arb_owner            last_owner;
    logic                cmd_rd;
    logic                cmd_wr;
    logic [MASK_W-1:0]   cmd_mask;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;

    logic                i_pend;
    logic                d_pend;
    logic                grant_i;
    logic                grant_d;

    assign i_pend = i_mem_read | i_mem_write;
    assign d_pend = d_mem_read | d_mem_write;

    // Idle-time grant decision: a tie goes to whoever did not own the port last.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == ARB_IDLE) begin
            grant_i = i_pend & (~d_pend | (last_owner == arb_owner_d));
            grant_d = d_pend & ~grant_i;
        end
    end

    // Arbitration FSM and command register; the command is frozen at grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            last_owner <= arb_owner_d;
            cmd_rd     <= 1'b0;
            cmd_wr     <= 1'b0;
            cmd_mask   <= '0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_i) begin
                        state                <= ARB_I;
                        last_owner           <= arb_owner_i;
                        {cmd_wr, cmd_rd}     <= cmd_encode(i_mem_read, i_mem_write);
                        cmd_mask             <= i_mem_byte_enable;
                        cmd_addr             <= i_mem_address;
                        cmd_wdata            <= i_mem_wdata;
                    end else if (grant_d) begin
                        state                <= ARB_D;
                        last_owner           <= arb_owner_d;
                        {cmd_wr, cmd_rd}     <= cmd_encode(d_mem_read, d_mem_write);
                        cmd_mask             <= d_mem_byte_enable;
                        cmd_addr             <= d_mem_address;
                        cmd_wdata            <= d_mem_wdata;
                    end
                end
                ARB_I, ARB_D: begin
                    if (pmem_resp) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Physical port is driven purely from state and the latched command.
    assign arb_busy         = (state != ARB_IDLE);
    assign pmem_read        = arb_busy & cmd_rd;
    assign pmem_write       = arb_busy & cmd_wr;
    assign pmem_byte_enable = cmd_mask;
    assign pmem_address     = cmd_addr;
    assign pmem_wdata       = cmd_wdata;

    // Completion reaches only the current owner; read data is shared, resp qualifies it.
    assign i_mem_resp  = (state == ARB_I) & pmem_resp;
    assign d_mem_resp  = (state == ARB_D) & pmem_resp;
    assign i_mem_rdata = pmem_rdata;
    assign d_mem_rdata = pmem_rdata;

endmodule
